// File: rtl/ud_sweep_pkg.sv
// Shared constants for the up/down counter sweep controller.
// State codes stay plain 3-bit constants so legacy logic can compare against them directly.
package ud_sweep_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CYC_W     = 8;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_UP   = 3'd2;
    localparam logic [2:0] S_DOWN = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/ud_sweep_ctrl.sv
// Drives an up/down loadable counter so its count sweeps as a triangle wave
// between a captured floor and ceiling for a programmed number of sweeps.
module ud_sweep_ctrl
    import ud_sweep_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [CYC_W-1:0] cycles,
    input  logic [WIDTH-1:0] count_in,
    output logic             load,
    output logic             u_d,
    output logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CYC_W-1:0] sweeps_done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] hi_r;
    logic [CYC_W-1:0] cyc_r;
    logic [CYC_W-1:0] sweeps_inc;
    logic             accept;
    logic             reject;
    logic             at_top;
    logic             at_bot;
    logic             last;
    logic             turn_up;

    // Turn one count early: the counter moves on the same edge the state changes.
    assign accept     = (state == S_IDLE) && start && !stop && (lo < hi);
    assign reject     = (state == S_IDLE) && start && !stop && !(lo < hi);
    assign at_top     = (count_in == (hi_r - ONE));
    assign at_bot     = (count_in == (lo_r + ONE));
    assign sweeps_inc = sweeps_done + CYC_W'(1);
    assign last       = (cyc_r != '0) && (sweeps_inc == cyc_r);
    assign turn_up    = (state == S_DOWN) && !stop && at_bot;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = S_LOAD;
            S_LOAD: state_nx = stop ? S_IDLE : S_UP;
            S_UP: begin
                if (stop)        state_nx = S_IDLE;
                else if (at_top) state_nx = S_DOWN;
            end
            S_DOWN: begin
                if (stop)        state_nx = S_IDLE;
                else if (at_bot) state_nx = last ? S_DONE : S_UP;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            lo_r        <= '0;
            hi_r        <= '0;
            cyc_r       <= '0;
            sweeps_done <= '0;
            err         <= 1'b0;
        end else begin
            state <= state_nx;
            err   <= reject;
            if (accept) begin
                lo_r        <= lo;
                hi_r        <= hi;
                cyc_r       <= cycles;
                sweeps_done <= '0;
            end else if (turn_up) begin
                sweeps_done <= sweeps_inc;
            end
        end
    end

    // Idle and done reload the counter with its own value, since it has no enable.
    always_comb begin
        load = 1'b1;
        u_d  = 1'b0;
        data = count_in;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_LOAD: begin
                data = lo_r;
                busy = 1'b1;
            end
            S_UP: begin
                load = 1'b0;
                u_d  = 1'b1;
                busy = 1'b1;
            end
            S_DOWN: begin
                load = 1'b0;
                busy = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule
